m_blit_step_counter: RTL and testbench
======================================

# m_blit_step_counter

Loadable address-stepping counter for the blitter's inner loop. It holds a WIDTH-bit address and a WIDTH-bit step, and advances the address by the step once per accepted advance request, for a programmed number of iterations. The addition is a ripple of 4-bit no-carry-out nibble adder slices; the block is the registered stage that feeds those slices and consumes their sum. Its outputs drive the blitter address bus and the blitter sequencer's loop-done logic.

## Interface
- WIDTH, 16, address/step width; must be a multiple of 4.
- CNT_W, 8, iteration counter width.
- CLK  in  1  sole clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- LOAD  in  1  load LD_ADDR, LD_STEP and LD_COUNT; honoured only in IDLE.
- LD_ADDR  in  WIDTH  initial address.
- LD_STEP  in  WIDTH  per-iteration increment.
- LD_COUNT  in  CNT_W  iteration count; 0 means 2^CNT_W.
- GO  in  1  start the loop; honoured only in IDLE.
- ADV  in  1  consumer accepts the current ADDR and requests the next one.
- SUB  in  1  step direction, present only with BLIT_SUB_EN.
- ADDR  out  WIDTH  current address (registered).
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse after the final advance.
- WRAP  out  1  sticky flag: some advance in this loop overflowed (or, when subtracting, borrowed) past WIDTH bits.

## Operation
- States: IDLE, RUN, FIN.
- Reset: state IDLE; ADDR, step and count registers are 0; BUSY=0, DONE=0, WRAP=0.
- IDLE:
  - LOAD captures all three load values.
  - GO moves to RUN and clears WRAP.
  - If LOAD and GO are high in the same cycle, the load applies and the loop runs on the newly loaded values.
- RUN, each cycle with ADV=1:
  - ADDR <= ADDR + step, modulo 2^WIDTH.
  - count <= count - 1.
  - WRAP is set if the carry out of the top nibble is 1.
  - If count was 1, go to FIN. A stored count of 0 runs 2^CNT_W iterations.
- RUN with ADV=0: all state holds.
- LOAD and GO are ignored in RUN and FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE. ADDR keeps its final value.
- Arithmetic: the sum is formed by WIDTH/4 chained nibble slices. Slice k takes its carry-in from the carry of slice k-1. The carry for each slice is generated in this block from the slice operands, because the slices emit no carry. The carry-in of slice 0 is 0 (or SUB; see Configuration).
- RESET in any state returns immediately to reset values. The loop is aborted and no DONE is produced.

## Timing
- ADDR updates on the edge where ADV is sampled high, so the new value is visible in the next cycle. One advance per cycle is allowed, so back-to-back ADV gives full throughput.
- BUSY rises the cycle after GO is sampled.
- DONE asserts the cycle after the final ADV; BUSY falls in that same cycle.
- Earliest re-GO: the cycle after DONE.
- Adder path: combinational through all slices into the ADDR register, within one cycle.

## Configuration
- BLIT_SUB_EN defined:
  - The SUB port exists.
  - When SUB=1, the operand is ~step and the slice 0 carry-in is 1, giving ADDR - step.
  - WRAP is set on borrow, i.e. when the top carry is 0.
  - SUB is sampled on every ADV.
- BLIT_SUB_EN undefined: no SUB port; add only.

## Structure
- Package blit_ctr_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - a NIBBLES = WIDTH/4 helper;
  - the reset-value constants.
- Sub-module m_blit_nib_add: one 4-bit slice (inputs X[3:0], Y[3:0], CIN; output Z[3:0]). It is instantiated NIBBLES times in a generate loop. Carry generation stays in the parent.

## Test plan
- Load ADDR=0x1000, STEP=0x0010, COUNT=3; GO; hold ADV=1 → ADDR reads 0x1010, 0x1020, 0x1030; then one DONE pulse; WRAP=0.
- Load ADDR=0xFFF8, STEP=0x0010, COUNT=1; GO; ADV → ADDR=0x0008, WRAP=1, DONE one cycle later.
- Load COUNT=0, STEP=1, ADDR=0; GO; ADV held → exactly 256 advances, final ADDR=0x0100, single DONE.
- Load ADDR=0x0040, STEP=2, COUNT=4; GO; ADV pattern 1,0,0,1,1,0,1 → ADDR steps only on the 1s; final ADDR=0x0048; LOAD pulsed mid-run is ignored.
- With BLIT_SUB_EN: load ADDR=0x0005, STEP=0x0008, COUNT=1; GO; SUB=1, ADV → ADDR=0xFFFD, WRAP=1.
- Mid-RUN RESET after 2 of 5 advances → next cycle state IDLE, ADDR=0, BUSY=0, WRAP=0, no DONE.

Source files
------------

// File: rtl/blit_ctr_pkg.sv
// Shared types, constants and helpers for the blitter address-stepping counter.
package blit_ctr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_FLAG  = 1'b0;

  function automatic int nibbles(input int width);
    return width / 4;
  endfunction

  // The nibble slices emit no carry, so the carry chain is rebuilt here from the slice operands.
  function automatic logic nib_carry(input logic [3:0] x, input logic [3:0] y, input logic cin);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    return s[4];
  endfunction

endpackage

// File: rtl/m_blit_nib_add.sv
// One 4-bit adder slice with carry-in and no carry-out.
module m_blit_nib_add (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       cin_i,
  output logic [3:0] z_o
);

  assign z_o = x_i + y_i + {3'b000, cin_i};

endmodule

// File: rtl/m_blit_step_counter.sv
// Loadable address-stepping counter for the blitter inner loop.
// Optional macro BLIT_SUB_EN adds the sub_i port for subtracting the step.
module m_blit_step_counter
  import blit_ctr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] ld_addr_i,
  input  logic [WIDTH-1:0] ld_step_i,
  input  logic [CNT_W-1:0] ld_count_i,
  input  logic             go_i,
  input  logic             adv_i,
`ifdef BLIT_SUB_EN
  input  logic             sub_i,
`endif
  output logic [WIDTH-1:0] addr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic             sub_s;
  logic [WIDTH-1:0] opnd_s;
  logic [WIDTH-1:0] sum_s;
  logic [NIBBLES:0] carry_s;
  logic             wrap_hit_s;
  logic             busy_s;
  logic             done_s;

`ifdef BLIT_SUB_EN
  assign sub_s = sub_i;
`else
  assign sub_s = 1'b0;
`endif

  // Subtraction is addition of the inverted step with a forced carry-in.
  assign opnd_s     = sub_s ? ~step_q : step_q;
  assign carry_s[0] = sub_s;
  assign wrap_hit_s = sub_s ? ~carry_s[NIBBLES] : carry_s[NIBBLES];

  for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
    m_blit_nib_add u_nib (
      .x_i   (addr_q[4*k +: 4]),
      .y_i   (opnd_s[4*k +: 4]),
      .cin_i (carry_s[k]),
      .z_o   (sum_s[4*k +: 4])
    );
    assign carry_s[k+1] = nib_carry(addr_q[4*k +: 4], opnd_s[4*k +: 4], carry_s[k]);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RST_STATE;
      addr_q  <= {WIDTH{1'b0}};
      step_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      wrap_q  <= RST_FLAG;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          addr_d = ld_addr_i;
          step_d = ld_step_i;
          cnt_d  = ld_count_i;
        end else begin
          addr_d = addr_q;
        end
        if (go_i) begin
          state_d = ST_RUN;
          wrap_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (adv_i) begin
          addr_d = sum_s;
          cnt_d  = cnt_q - CNT_ONE;
          wrap_d = wrap_q | wrap_hit_s;
          // A stored count of zero wraps to all-ones here, giving 2^CNT_W iterations.
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status decode from the registered state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      ST_RUN:  busy_s = 1'b1;
      ST_FIN:  done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  assign addr_o = addr_q;
  assign busy_o = busy_s;
  assign done_o = done_s;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_m_blit_step_counter.sv
// Self-checking bench for m_blit_step_counter: vector table, corner sequences and randomized loops.
module tb_m_blit_step_counter;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [W-1:0]  ld_addr;
  logic [W-1:0]  ld_step;
  logic [CW-1:0] ld_count;
  logic          go;
  logic          adv;
  logic          sub;
  logic [W-1:0]  addr;
  logic          busy;
  logic          done;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer arithmetic over the loop.
  int unsigned m_addr;
  int unsigned m_step;
  int          m_left;
  bit          m_wrap;
  int          m_advs;

  always #5 clk = ~clk;

  m_blit_step_counter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (load),
    .ld_addr_i  (ld_addr),
    .ld_step_i  (ld_step),
    .ld_count_i (ld_count),
    .go_i       (go),
    .adv_i      (adv),
`ifdef BLIT_SUB_EN
    .sub_i      (sub),
`endif
    .addr_o     (addr),
    .busy_o     (busy),
    .done_o     (done),
    .wrap_o     (wrap)
  );

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  s;
    logic [CW-1:0] c;
    bit            together;
    logic [W-1:0]  exp_addr;
    bit            exp_wrap;
    int            exp_n;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_addr = 0; m_step = 0; m_wrap = 1'b0; m_left = 0;
  endtask

  task automatic load_go(input logic [W-1:0] a, input logic [W-1:0] s,
                         input logic [CW-1:0] c, input bit together);
    ld_addr = a; ld_step = s; ld_count = c; load = 1'b1; go = together;
    tick();
    if (!together) begin
      load = 1'b0; go = 1'b1;
      ld_addr = W'($urandom); ld_step = W'($urandom);
      tick();
    end
    load = 1'b0; go = 1'b0;
    m_addr = a; m_step = s; m_wrap = 1'b0; m_advs = 0;
    m_left = (c == 0) ? (1 << CW) : int'(c);
    chk("go_busy", busy, 1);
    chk("go_wrap_clr", wrap, 0);
    chk("go_addr", addr, m_addr);
  endtask

  // One RUN cycle; LOAD/GO get junk that must be ignored.
  task automatic adv_cycle(input bit a, input bit s);
    bit eff_sub;
    adv = a; sub = s;
    load = 1'($urandom); go = 1'($urandom);
    ld_addr = W'($urandom); ld_step = W'($urandom); ld_count = CW'($urandom);
    tick();
`ifdef BLIT_SUB_EN
    eff_sub = s;
`else
    eff_sub = 1'b0;
`endif
    if (a) begin
      if (eff_sub) begin
        if (m_addr < m_step) m_wrap = 1'b1;
        m_addr = (m_addr - m_step) % 65536;
      end else begin
        if (m_addr + m_step > 65535) m_wrap = 1'b1;
        m_addr = (m_addr + m_step) % 65536;
      end
      m_left--; m_advs++;
    end
    adv = 1'b0; load = 1'b0; go = 1'b0; sub = 1'b0;
    chk("run_addr", addr, m_addr);
    chk("run_wrap", wrap, m_wrap);
    chk("run_busy", busy, (m_left > 0));
    chk("run_done", done, (a && m_left == 0));
  endtask

  // FIN cycle just observed; LOAD/GO driven now must be ignored.
  task automatic fin_cycle();
    load = 1'b1; go = 1'b1; ld_addr = 16'hDEAD; ld_count = 8'd3;
    tick();
    load = 1'b0; go = 1'b0;
    chk("fin_done_off", done, 0);
    chk("fin_busy", busy, 0);
    chk("fin_addr_hold", addr, m_addr);
    chk("fin_wrap_hold", wrap, m_wrap);
    tick();
    chk("idle_no_go", busy, 0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; go = 1'b0; adv = 1'b0; sub = 1'b0;
    ld_addr = '0; ld_step = '0; ld_count = '0;
    tbl[0] = '{16'h1000, 16'h0010, 8'd3, 1'b0, 16'h1030, 1'b0, 3};
    tbl[1] = '{16'hFFF8, 16'h0010, 8'd1, 1'b1, 16'h0008, 1'b1, 1};
    tbl[2] = '{16'h0000, 16'h0001, 8'd0, 1'b0, 16'h0100, 1'b0, 256};
    tbl[3] = '{16'h8000, 16'h8000, 8'd2, 1'b1, 16'h8000, 1'b1, 2};
    tbl[4] = '{16'h1234, 16'h1111, 8'd4, 1'b0, 16'h5678, 1'b0, 4};
    tbl[5] = '{16'hFFFF, 16'h0001, 8'd2, 1'b1, 16'h0001, 1'b1, 2};

    tick();
    reset = 1'b0;
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);

    for (int i = 0; i < 6; i++) begin
      load_go(tbl[i].a, tbl[i].s, tbl[i].c, tbl[i].together);
      while (m_left > 0) adv_cycle(1'b1, 1'b0);
      chk("tbl_final_addr", addr, tbl[i].exp_addr);
      chk("tbl_wrap", wrap, tbl[i].exp_wrap);
      chk("tbl_adv_count", m_advs, tbl[i].exp_n);
      fin_cycle();
    end

    // Stalls: address moves only on ADV=1 cycles.
    begin
      bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      load_go(16'h0040, 16'h0002, 8'd4, 1'b0);
      for (int i = 0; i < 7; i++) adv_cycle(pat[i], 1'b0);
      chk("stall_final", addr, 16'h0048);
      chk("stall_done", done, 1);
      fin_cycle();
    end

`ifdef BLIT_SUB_EN
    load_go(16'h0005, 16'h0008, 8'd1, 1'b0);
    adv_cycle(1'b1, 1'b1);
    chk("sub_addr", addr, 16'hFFFD);
    chk("sub_wrap", wrap, 1);
    fin_cycle();
`endif

    // Reset mid-run after 2 of 5 advances, with WRAP already set.
    load_go(16'hFF00, 16'h0100, 8'd5, 1'b1);
    adv_cycle(1'b1, 1'b0);
    adv_cycle(1'b1, 1'b0);
    chk("pre_rst_wrap", wrap, 1);
    reset = 1'b1; adv = 1'b1;
    tick();
    reset = 1'b0; adv = 1'b0;
    chk("mrst_addr", addr, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_wrap", wrap, 0);
    chk("mrst_done", done, 0);
    adv = 1'b1;
    tick();
    adv = 1'b0;
    chk("mrst_no_done", done, 0);
    chk("mrst_idle", busy, 0);
    m_addr = 0; m_wrap = 1'b0;

    // Randomized loops with random stalls, direction and load style.
    for (int r = 0; r < 40; r++) begin
      int guard;
      load_go(W'($urandom), W'($urandom), CW'($urandom_range(1, 12)), 1'($urandom));
      guard = 0;
      while (m_left > 0 && guard < 500) begin
        adv_cycle(($urandom_range(0, 3) != 0), 1'($urandom));
        guard++;
      end
      if (m_left > 0) begin
        chk("loop_budget", 0, 1);
        do_reset();
      end else begin
        fin_cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
